// File: rtl/cv32e40x_b_clmul_if.sv
// Request/response handshake bundle for the Zbc carry-less multiplier.
// The slave modport is the multiplier; the master modport is the EX-stage driver.
interface cv32e40x_b_clmul_if;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, ready_i,
        input  ready_o, valid_o, result_o
    );
endinterface

// File: rtl/cv32e40x_b_clmul.sv
// Iterative carry-less multiplier for clmul/clmulh/clmulr, BITS_PER_CYCLE bits of rs2 per cycle.
// Optional macro CV32E40X_CLMUL_EARLY_EXIT_EN finishes as soon as the remaining rs2 bits are zero.
module cv32e40x_b_clmul #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned LEN            = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 kill_i,
    cv32e40x_b_clmul_if.slave    bus,
    output logic                 busy_o
);

    localparam int unsigned N     = LEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (LEN != 32) begin : g_len_chk
        $error("cv32e40x_b_clmul: LEN must be 32");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32)) begin : g_bpc_chk
        $error("cv32e40x_b_clmul: illegal BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q;
    logic [31:0]      b_q;
    logic [63:0]      a_sh_q;
    logic [63:0]      acc_q;
    logic [63:0]      partial;
    logic [63:0]      acc_nxt;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      result_q;
    logic             valid_q;
    logic             ready_q;
    logic             busy_q;
    logic             last_iter;

    // b_q and a_sh_q shift every cycle, so the low bits of b_q always pair with a_sh_q.
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_q[j]) begin
                partial = partial ^ (a_sh_q << j);
            end
        end
    end

    assign acc_nxt = acc_q ^ partial;

`ifdef CV32E40X_CLMUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_W'(N - 1)) || (b_q == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(N - 1));
`endif

    function automatic logic [31:0] select_result(input logic [1:0] op, input logic [63:0] acc);
        case (op)
            2'b01:   select_result = acc[63:32];
            2'b10:   select_result = acc[62:31];
            default: select_result = acc[31:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            b_q      <= '0;
            a_sh_q   <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else if (kill_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        a_sh_q  <= {32'b0, bus.operand_a_i};
                        b_q     <= bus.operand_b_i;
                        op_q    <= bus.op_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    acc_q  <= acc_nxt;
                    a_sh_q <= a_sh_q << BITS_PER_CYCLE;
                    b_q    <= b_q >> BITS_PER_CYCLE;
                    if (cnt_q != CNT_W'(N - 1)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (last_iter) begin
                        result_q <= select_result(op_q, acc_nxt);
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (valid_q && bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign busy_o       = busy_q;

    op_legal: assert property (@(posedge clk) disable iff (!rst_n) bus.valid_i |-> bus.op_i != 2'b11);

endmodule

// File: tb/tb_cv32e40x_b_clmul.sv
// Directed bench for cv32e40x_b_clmul: one instance per legal BITS_PER_CYCLE, shared stimulus.
// Instance 0 (BITS_PER_CYCLE=1) carries the latency, kill and backpressure checks.
module tb_cv32e40x_b_clmul;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        kill_i  = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [1:0]  op_i    = 2'b00;
    logic [31:0] a_i     = '0;
    logic [31:0] b_i     = '0;

    logic [5:0]  v_all;
    logic [5:0]  r_all;
    logic [5:0]  busy_all;
    logic [31:0] res_all [6];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        cv32e40x_b_clmul_if bif ();
        assign bif.valid_i     = valid_i;
        assign bif.op_i        = op_i;
        assign bif.operand_a_i = a_i;
        assign bif.operand_b_i = b_i;
        assign bif.ready_i     = ready_i;

        cv32e40x_b_clmul #(.BITS_PER_CYCLE(1 << g)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .kill_i (kill_i),
            .bus    (bif.slave),
            .busy_o (busy_all[g])
        );

        assign v_all[g]   = bif.valid_o;
        assign r_all[g]   = bif.ready_o;
        assign res_all[g] = bif.result_o;
    end

    function automatic int exp_lat(input int bpc, input logic [31:0] b);
        int n;
`ifdef CV32E40X_CLMUL_EARLY_EXIT_EN
        int msb;
        int e;
`endif
        n = 32 / bpc;
`ifdef CV32E40X_CLMUL_EARLY_EXIT_EN
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        e = 2 + (msb + bpc) / bpc;
        return (e < n + 1) ? e : n + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (r_all == 6'h3f) break;
        end
        chk("all_idle", {26'b0, r_all}, 32'h3f);
    endtask

    // Leaves the bench at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        int lat;
        ready_i = 1'b1;
        wait_idle();
        issue(op, a, b);
        lat = 1;
        while (!v_all[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_res"}, res_all[0], exp);
        chk({tag, "_lat"}, lat, exp_lat(1, b));
    endtask

    task automatic run_all(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit bp);
        int cyc;
        wait_idle();
        ready_i = 1'b0;
        issue(op, a, b);
        cyc = 1;
        while (v_all != 6'h3f && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_all_valid"}, {26'b0, v_all}, 32'h3f);
        for (int g = 0; g < 6; g++) chk($sformatf("%s_bpc%0d", tag, 1 << g), res_all[g], exp);
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                valid_i = 1'b1;
                a_i     = 32'h0000_0003;
                b_i     = 32'h0000_0003;
                op_i    = 2'b00;
                @(negedge clk);
                chk("bp_result", res_all[0], exp);
                chk("bp_ready", {31'b0, r_all[0]}, 32'd0);
                chk("bp_valid", {31'b0, v_all[0]}, 32'd1);
            end
            valid_i = 1'b0;
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_released_valid"}, {26'b0, v_all}, 32'h0);
        chk({tag, "_released_ready"}, {26'b0, r_all}, 32'h3f);
    endtask

    initial begin
        int seen;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, r_all[0]}, 32'd1);
        chk("rst_valid", {31'b0, v_all[0]}, 32'd0);
        chk("rst_busy", {26'b0, busy_all}, 32'd0);
        chk("rst_result", res_all[0], 32'h0);
        rst_n = 1'b1;

        run1("clmul_3x3", 2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005);
        run1("clmul_msb", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run1("clmulh_msb", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run1("clmulr_msb", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run1("clmul_b1", 2'b00, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF);
        run1("clmulr_b1", 2'b10, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0001);
        run1("clmul_b2", 2'b00, 32'hDEAD_BEEF, 32'h0000_0002, 32'hBD5B_7DDE);
        run1("clmulh_b2", 2'b01, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0001);
        run1("clmul_b0", 2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000);

        run_all("ones_clmul", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1);
        run_all("ones_clmulh", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
        run_all("ones_clmulr", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0);

        // Kill at iteration 5: instance 0 is at counter 5 five cycles after T+1.
        ready_i = 1'b1;
        wait_idle();
        issue(2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (5) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_busy", {31'b0, busy_all[0]}, 32'd0);
        chk("kill_ready", {31'b0, r_all[0]}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (v_all[0]) seen = 1;
            @(negedge clk);
        end
        chk("kill_no_valid", seen, 32'd0);
        run1("after_kill", 2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005);

        wait_idle();
        kill_i  = 1'b1;
        valid_i = 1'b1;
        @(negedge clk);
        kill_i  = 1'b0;
        valid_i = 1'b0;
        chk("kill_with_valid", {26'b0, busy_all}, 32'd0);

        wait_idle();
        issue(2'b00, 32'h0000_0003, 32'h0000_0003);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {26'b0, busy_all}, 32'd0);
        chk("async_rst_ready", {26'b0, r_all}, 32'h3f);
        @(negedge clk);
        rst_n = 1'b1;
        run1("after_rst", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
